// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the Ethernet transmit appender and receive checker.
package crc32_pkg;

   localparam int CRC_WIDTH = 32;
   localparam int NIBBLE_W  = 4;

   localparam logic [CRC_WIDTH-1:0] CRC32_POLY   = 32'h04C11DB7;
   localparam logic [CRC_WIDTH-1:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [CRC_WIDTH-1:0] CRC32_XOROUT = 32'hFFFFFFFF;

   // IFG is only reachable when the inter-frame gap feature is built in.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      FCS  = 2'd2,
      IFG  = 2'd3
   } state_e;

   function automatic logic [CRC_WIDTH-1:0] reflect32(input logic [CRC_WIDTH-1:0] v);
      logic [CRC_WIDTH-1:0] r;
      for (int i = 0; i < CRC_WIDTH; i++) begin
         r[i] = v[CRC_WIDTH-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_tx_append_if.sv
// Payload stream in, nibble PHY transmit out; slave modport is the appender's view.
interface crc32_tx_append_if;

   logic                          s_valid;
   logic                          s_ready;
   logic [crc32_pkg::NIBBLE_W-1:0] s_data;
   logic                          s_last;
   logic                          tx_en;
   logic [crc32_pkg::NIBBLE_W-1:0] tx_data;
   logic                          tx_done;
   logic                          tx_err;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, tx_en, tx_data, tx_done, tx_err
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, tx_en, tx_data, tx_done, tx_err
   );

endinterface

// File: rtl/crc32_nibble_lfsr.sv
// Combinational reflected CRC-32 step over one nibble, bit 0 first; shared with the receive checker.
module crc32_nibble_lfsr
   import crc32_pkg::*;
#(
   parameter logic [CRC_WIDTH-1:0] CRC_POLY = CRC32_POLY
) (
   input  logic [CRC_WIDTH-1:0] crc_in,
   input  logic [NIBBLE_W-1:0]  nibble,
   output logic [CRC_WIDTH-1:0] crc_out
);

   localparam logic [CRC_WIDTH-1:0] POLY_REFL = reflect32(CRC_POLY);

   always_comb begin
      crc_out = crc_in;
      // NOTE: blocking assignments chain the four bit steps within one evaluation.
      for (int i = 0; i < NIBBLE_W; i++) begin
         if (crc_out[0] ^ nibble[i]) begin
            crc_out = (crc_out >> 1) ^ POLY_REFL;
         end else begin
            crc_out = crc_out >> 1;
         end
      end
   end

endmodule

// File: rtl/crc32_tx_append.sv
// Nibble transmit path: echoes payload one cycle late and appends the 8-nibble Ethernet FCS.
// Optional inter-frame gap state is built when CRC_TX_IFG_EN is defined.
module crc32_tx_append
   import crc32_pkg::*;
#(
`ifdef CRC_TX_IFG_EN
   parameter int unsigned          IFG_NIBBLES = 24,
`endif
   parameter logic [CRC_WIDTH-1:0] CRC_POLY    = CRC32_POLY,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT    = CRC32_INIT,
   parameter logic [CRC_WIDTH-1:0] CRC_XOROUT  = CRC32_XOROUT
) (
   input  logic             clk_25Mz,
   input  logic             rst,
   crc32_tx_append_if.slave bus
);

   state_e                 r_state,   w_state_nxt;
   logic [CRC_WIDTH-1:0]   r_crc,     w_crc_nxt;
   logic [CRC_WIDTH-1:0]   r_fcs,     w_fcs_nxt;
   logic [2:0]             r_fcs_idx, w_fcs_idx_nxt;
   logic                   r_tx_en,   w_tx_en_nxt;
   logic [NIBBLE_W-1:0]    r_tx_data, w_tx_data_nxt;
   logic                   r_tx_done, w_tx_done_nxt;
   logic                   r_tx_err,  w_tx_err_nxt;
`ifdef CRC_TX_IFG_EN
   logic [4:0]             r_ifg_cnt, w_ifg_cnt_nxt;
`endif

   logic                   w_ready;
   logic                   w_accept;
   logic [CRC_WIDTH-1:0]   w_crc_upd;

   crc32_nibble_lfsr #(
      .CRC_POLY (CRC_POLY)
   ) u_lfsr (
      .crc_in  (r_crc),
      .nibble  (bus.s_data),
      .crc_out (w_crc_upd)
   );

   // Ready is held low throughout reset, not just from the first edge.
   assign w_ready  = !rst && ((r_state == IDLE) || (r_state == DATA));
   assign w_accept = bus.s_valid && w_ready;

   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch.
      w_state_nxt   = r_state;
      w_crc_nxt     = r_crc;
      w_fcs_nxt     = r_fcs;
      w_fcs_idx_nxt = r_fcs_idx;
      w_tx_en_nxt   = 1'b0;
      w_tx_data_nxt = '0;
      w_tx_done_nxt = 1'b0;
      w_tx_err_nxt  = 1'b0;
`ifdef CRC_TX_IFG_EN
      w_ifg_cnt_nxt = r_ifg_cnt;
`endif

      case (r_state)
         IDLE, DATA: begin
            if (w_accept) begin
               w_tx_en_nxt   = 1'b1;
               w_tx_data_nxt = bus.s_data;
               if (bus.s_last) begin
                  w_state_nxt   = FCS;
                  w_fcs_nxt     = w_crc_upd ^ CRC_XOROUT;
                  w_crc_nxt     = CRC_INIT;
                  w_fcs_idx_nxt = '0;
               end else begin
                  w_state_nxt = DATA;
                  w_crc_nxt   = w_crc_upd;
               end
            end else if (r_state == DATA) begin
               // The PHY cannot stall, so a missing nibble aborts the frame.
               w_tx_err_nxt = 1'b1;
               w_state_nxt  = IDLE;
               w_crc_nxt    = CRC_INIT;
            end
         end

         FCS: begin
            w_tx_en_nxt   = 1'b1;
            w_tx_data_nxt = r_fcs[{r_fcs_idx, 2'b00} +: NIBBLE_W];
            w_fcs_idx_nxt = r_fcs_idx + 3'd1;
            if (r_fcs_idx == 3'd7) begin
               w_tx_done_nxt = 1'b1;
`ifdef CRC_TX_IFG_EN
               w_state_nxt   = IFG;
               w_ifg_cnt_nxt = 5'(IFG_NIBBLES - 1);
`else
               w_state_nxt   = IDLE;
`endif
            end
         end

`ifdef CRC_TX_IFG_EN
         IFG: begin
            if (r_ifg_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_ifg_cnt_nxt = r_ifg_cnt - 5'd1;
            end
         end
`endif

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_25Mz or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_crc     <= CRC_INIT;
         r_fcs     <= '0;
         r_fcs_idx <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_crc     <= w_crc_nxt;
         r_fcs     <= w_fcs_nxt;
         r_fcs_idx <= w_fcs_idx_nxt;
         r_tx_en   <= w_tx_en_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_tx_done <= w_tx_done_nxt;
         r_tx_err  <= w_tx_err_nxt;
      end
   end

`ifdef CRC_TX_IFG_EN
   always_ff @(posedge clk_25Mz or posedge rst) begin
      if (rst) begin
         r_ifg_cnt <= '0;
      end else begin
         r_ifg_cnt <= w_ifg_cnt_nxt;
      end
   end
`endif

   assign bus.s_ready = w_ready;
   assign bus.tx_en   = r_tx_en;
   assign bus.tx_data = r_tx_data;
   assign bus.tx_done = r_tx_done;
   assign bus.tx_err  = r_tx_err;

endmodule

// File: tb/tb_crc32_tx_append.sv
// Scoreboard bench for crc32_tx_append: stimulus queues expected PHY nibbles, a monitor compares them.
module tb_crc32_tx_append;
   import crc32_pkg::*;

   typedef struct packed {
      logic       en;
      logic [3:0] data;
      logic       done;
      logic       err;
   } obs_t;

`ifdef CRC_TX_IFG_EN
   localparam int GAP = 24;
`else
   localparam int GAP = 0;
`endif
   localparam int EXP_STALL = 8 + GAP;

   logic clk_25Mz = 1'b0;
   logic rst;

   crc32_tx_append_if bus ();

   crc32_tx_append dut (
      .clk_25Mz (clk_25Mz),
      .rst      (rst),
      .bus      (bus)
   );

   always #20 clk_25Mz = ~clk_25Mz;

   int          checks   = 0;
   int          failures = 0;
   obs_t        exp_q[$];
   logic [31:0] fcs_sh   = '0;
   logic [31:0] dut_fcs  = '0;
   int          en_count = 0;
   int          err_count = 0;
   int          zero_run = 0;
   int          gap_after_done = -1;
   bit          measuring = 1'b0;

   logic [3:0] ascii[$] = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5,
                            4'h3, 4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t mk(input logic en, input logic [3:0] d, input logic done, input logic err);
      obs_t o;
      o.en = en; o.data = d; o.done = done; o.err = err;
      return o;
   endfunction

   // Reference FCS: flatten the frame into its serial bit stream and divide bit by bit.
   function automatic logic [31:0] model_fcs(input logic [3:0] nib[$]);
      bit          bits[$];
      logic [31:0] c;
      foreach (nib[k]) begin
         for (int b = 0; b < 4; b++) bits.push_back(nib[k][b]);
      end
      c = 32'hFFFFFFFF;
      foreach (bits[j]) begin
         if (c[0] ^ bits[j]) c = (c >> 1) ^ 32'hEDB88320;
         else                c = c >> 1;
      end
      return c ^ 32'hFFFFFFFF;
   endfunction

   // Monitor: every cycle with any PHY flag raised must match the head of the queue.
   always @(negedge clk_25Mz) begin
      obs_t o;
      obs_t e;
      if (!rst) begin
         if (measuring) begin
            if (!bus.tx_en) zero_run++;
            else begin
               gap_after_done = zero_run;
               measuring = 1'b0;
            end
         end
         if (bus.tx_en || bus.tx_err || bus.tx_done) begin
            o = mk(bus.tx_en, bus.tx_data, bus.tx_done, bus.tx_err);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_output actual=0x%0h expected=none", o);
            end else begin
               e = exp_q.pop_front();
               check("tx_out", 32'(o), 32'(e));
            end
            if (bus.tx_en) begin
               en_count++;
               fcs_sh = {bus.tx_data, fcs_sh[31:4]};
            end
            if (bus.tx_err) err_count++;
            if (bus.tx_done) begin
               dut_fcs   = fcs_sh;
               measuring = 1'b1;
               zero_run  = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_25Mz);
      #1;
   endtask

   task automatic idle(input int n);
      bus.s_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.s_last = 1'($urandom);
         bus.s_data = 4'($urandom);
         tick();
      end
      bus.s_last = 1'b0;
   endtask

   // drop_after < 0: complete frame; otherwise send that many nibbles then starve the DUT.
   task automatic send_frame(input logic [3:0] nib[$], input int drop_after, output int first_stalls);
      int          n;
      int          stalls;
      logic [31:0] f;
      n = (drop_after < 0) ? nib.size() : drop_after;
      first_stalls = 0;
      for (int k = 0; k < n; k++) begin
         stalls = 0;
         bus.s_valid = 1'b1;
         bus.s_data  = nib[k];
         bus.s_last  = (drop_after < 0) && (k == n - 1);
         @(negedge clk_25Mz);
         while (!bus.s_ready && stalls < 100) begin
            stalls++;
            tick();
            @(negedge clk_25Mz);
         end
         if (!bus.s_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1");
            break;
         end
         if (k == 0) first_stalls = stalls;
         exp_q.push_back(mk(1'b1, nib[k], 1'b0, 1'b0));
         if (bus.s_last) begin
            f = model_fcs(nib);
            for (int j = 0; j < 8; j++) exp_q.push_back(mk(1'b1, f[4*j +: 4], j == 7, 1'b0));
         end
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = 4'($urandom);
      if (drop_after >= 0) begin
         exp_q.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1));
         tick();
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      bus.s_valid = 1'b0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   function automatic void rand_frame(output logic [3:0] q[$], input int len);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(4'($urandom));
   endfunction

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      int          len;
      logic [3:0]  fa[$];
      logic [3:0]  fb[$];
      logic [31:0] f;

      bus.s_valid = 1'b0;
      bus.s_data  = 4'h0;
      bus.s_last  = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk_25Mz);
      #1;
      bus.s_valid = 1'b1;
      #5;
      check("rst_tx_en",   bus.tx_en,   0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_tx_done", bus.tx_done, 0);
      check("rst_tx_err",  bus.tx_err,  0);
      check("rst_s_ready", bus.s_ready, 0);
      bus.s_valid = 1'b0;
      tick();
      rst = 1'b0;
      idle(2);

      // Check string through the full path.
      send_frame(ascii, -1, st);
      drain("t1_drain");
      check("t1_fcs", dut_fcs, 32'hCBF43926);

      // One-nibble frame: payload plus 8 FCS nibbles.
      en_count = 0;
      fa.delete();
      fa.push_back(4'h0);
      send_frame(fa, -1, st);
      drain("t2_drain");
      check("t2_en_cycles", en_count, 9);
      check("t2_fcs", dut_fcs, model_fcs(fa));

      // Underrun after 5 nibbles, then a clean frame.
      en_count  = 0;
      err_count = 0;
      rand_frame(fa, 10);
      send_frame(fa, 5, st);
      drain("t3_drain");
      check("t3_err_pulses", err_count, 1);
      check("t3_en_cycles",  en_count,  5);
      rand_frame(fb, 7);
      send_frame(fb, -1, st);
      drain("t3b_drain");
      check("t3b_fcs", dut_fcs, model_fcs(fb));

      // Back-to-back frames with valid held high.
      rand_frame(fa, 6);
      rand_frame(fb, 7);
      send_frame(fa, -1, st);
      gap_after_done = -1;
      send_frame(fb, -1, st);
      check("t4_ready_low_cycles", st, EXP_STALL);
      drain("t4_drain");
      check("t4_tx_en_gap", gap_after_done, GAP);
      check("t4_fcs", dut_fcs, model_fcs(fb));

      // Reset while the third FCS nibble is on the pins.
      send_frame(ascii, -1, st);
      tick();
      tick();
      tick();
      f = model_fcs(ascii);
      check("t5_pre_rst_nibble", bus.tx_data, 32'(f[11:8]));
      #4;
      rst = 1'b1;
      #1;
      check("t5_rst_tx_en",   bus.tx_en,   0);
      check("t5_rst_tx_data", bus.tx_data, 0);
      check("t5_rst_s_ready", bus.s_ready, 0);
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      idle(1);
      send_frame(ascii, -1, st);
      drain("t5_drain");
      check("t5_fcs", dut_fcs, 32'hCBF43926);

      // Randomized frames, gaps and underruns.
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(1, 16);
         rand_frame(fa, len);
         if (len >= 2 && $urandom_range(0, 4) == 0) send_frame(fa, $urandom_range(1, len - 1), st);
         else                                       send_frame(fa, -1, st);
         idle($urandom_range(0, 3));
      end
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
